cache_data_bank: RTL and testbench

//  N-way, byte-maskable cache data store with registered (1-cycle) read and write-first forwarding.

---
 rtl/cache_pkg.sv | 20 ++
 rtl/cache_data_way.sv | 36 +++
 rtl/cache_data_bank.sv | 109 ++++++++++
 tb/tb_cache_data_bank.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache data bank.
//  S_OFFSET_DEF : default line offset width
//  s_mask()     : bytes per line for a given offset width
//  s_line()     : bits per line for a given offset width
//  bank_state_t : bank init/operational state
package cache_pkg;

  localparam int S_OFFSET_DEF = 5;

  function automatic int s_mask(input int off);
    return 2 ** off;
  endfunction

  function automatic int s_line(input int off);
    return 8 * (2 ** off);
  endfunction

  typedef enum logic {INIT, READY} bank_state_t;

endpackage

// File: rtl/cache_data_way.sv
// One cache way: NUM_SETS lines of S_LINE bits.
//  clk    : clock
//  we     : byte write mask (0 = no write)
//  windex : write set
//  datain : write line
//  rindex : read set
//  rdata  : combinational read of rindex (pre-write contents)
module cache_data_way
  import cache_pkg::*;
#(
  parameter int S_INDEX  = 3,
  parameter int S_OFFSET = S_OFFSET_DEF,
  localparam int S_MASK  = s_mask(S_OFFSET),
  localparam int S_LINE  = s_line(S_OFFSET)
) (
  input  logic               clk,
  input  logic [S_MASK-1:0]  we,
  input  logic [S_INDEX-1:0] windex,
  input  logic [S_LINE-1:0]  datain,
  input  logic [S_INDEX-1:0] rindex,
  output logic [S_LINE-1:0]  rdata
);

  localparam int NUM_SETS = 2 ** S_INDEX;

  // No reset: contents are cleared by the bank's init sweep.
  logic [S_LINE-1:0] mem [NUM_SETS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < S_MASK; i++)
      if (we[i]) mem[windex][i*8 +: 8] <= datain[i*8 +: 8];
  end

  assign rdata = mem[rindex];

endmodule

// File: rtl/cache_data_bank.sv
// N-way byte-maskable cache data bank, 1-cycle registered read,
// write-first forwarding, self-zeroing init sweep after reset.
//  clk, rst  : clock, synchronous active-high reset
//  ready     : init sweep done, accesses accepted
//  rd_en     : read request, rindex = read set
//  rvalid    : dataout holds data for the read accepted last cycle
//  dataout   : all ways of the read set, way w at [w*S_LINE +: S_LINE]
//  write_en  : byte write mask (0 = no write), windex/wway/datain
module cache_data_bank
  import cache_pkg::*;
#(
  parameter int S_INDEX  = 3,
  parameter int S_OFFSET = S_OFFSET_DEF,
  parameter int NUM_WAYS = 2,
  localparam int S_MASK  = s_mask(S_OFFSET),
  localparam int S_LINE  = s_line(S_OFFSET),
  localparam int S_WAY   = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ready,
  input  logic                       rd_en,
  input  logic [S_INDEX-1:0]         rindex,
  output logic                       rvalid,
  output logic [NUM_WAYS*S_LINE-1:0] dataout,
  input  logic [S_MASK-1:0]          write_en,
  input  logic [S_INDEX-1:0]         windex,
  input  logic [S_WAY-1:0]           wway,
  input  logic [S_LINE-1:0]          datain
);

  localparam int NUM_SETS = 2 ** S_INDEX;

  bank_state_t state_q, state_d;
  logic [S_INDEX-1:0] init_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= INIT;
      init_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == INIT && init_cnt == S_INDEX'(NUM_SETS - 1)) state_d = READY;
  end

  assign ready = (state_q == READY);

  // During INIT every way is written with zeros at set init_cnt.
  logic [S_INDEX-1:0] widx;
  logic [S_LINE-1:0]  wdata;
  logic               fwd_hit;

  assign widx    = ready ? windex : init_cnt;
  assign wdata   = ready ? datain : '0;
  assign fwd_hit = (rindex == windex);

  logic [NUM_WAYS-1:0][S_MASK-1:0] we;
  logic [NUM_WAYS-1:0][S_LINE-1:0] rdata, merged;

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    // rst gating drops any write coinciding with a reset edge.
    always_comb begin
      we[w] = '0;
      if (!rst) begin
        if (!ready)                    we[w] = '1;
        else if (wway == S_WAY'(w))    we[w] = write_en;
      end
    end

    cache_data_way #(.S_INDEX(S_INDEX), .S_OFFSET(S_OFFSET)) u_way (
      .clk    (clk),
      .we     (we[w]),
      .windex (widx),
      .datain (wdata),
      .rindex (rindex),
      .rdata  (rdata[w])
    );

    // Write-first: same-set write bytes override the array read.
    always_comb begin
      merged[w] = rdata[w];
      for (int i = 0; i < S_MASK; i++)
        if (fwd_hit && we[w][i]) merged[w][i*8 +: 8] = datain[i*8 +: 8];
    end
  end

  logic [NUM_WAYS-1:0][S_LINE-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      dout_q <= '0;
    end else if (ready && rd_en) begin
      rvalid <= 1'b1;
      dout_q <= merged;
    end else begin
      rvalid <= 1'b0;
    end
  end

  assign dataout = dout_q;

endmodule

// File: tb/tb_cache_data_bank.sv
module tb_cache_data_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: default parameters (8 sets, 2 ways, 32-byte lines)
  logic         rst = 1'b1, ready, rd_en = 1'b0, rvalid;
  logic [2:0]   rindex = '0, windex = '0;
  logic [511:0] dataout;
  logic [31:0]  write_en = '0;
  logic [0:0]   wway = '0;
  logic [255:0] datain = '0;

  cache_data_bank dut (
    .clk(clk), .rst(rst), .ready(ready), .rd_en(rd_en), .rindex(rindex),
    .rvalid(rvalid), .dataout(dataout), .write_en(write_en), .windex(windex),
    .wway(wway), .datain(datain));

  // DUT 1: single way, 2 sets
  logic         rst1 = 1'b1, ready1, rd1 = 1'b0, rvalid1;
  logic [0:0]   ri1 = '0, wi1 = '0, wway1 = '0;
  logic [255:0] dout1, din1 = '0;
  logic [31:0]  wm1 = '0;

  cache_data_bank #(.S_INDEX(1), .NUM_WAYS(1)) dut1 (
    .clk(clk), .rst(rst1), .ready(ready1), .rd_en(rd1), .rindex(ri1),
    .rvalid(rvalid1), .dataout(dout1), .write_en(wm1), .windex(wi1),
    .wway(wway1), .datain(din1));

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] merge(input logic [255:0] old, input logic [255:0] nw,
                                         input logic [31:0] m);
    logic [255:0] r = old;
    for (int i = 0; i < 32; i++) if (m[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  // Reference model for DUT 0
  logic [255:0] m_mem [8][2];
  logic         m_ready = 1'b0;
  int           m_cnt = 0;
  logic [511:0] m_out = '0;
  logic [511:0] sb [$];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Model the edge from the currently driven inputs, clock it, compare.
  task automatic step(input string nm);
    bit exp_v = 0;
    logic [511:0] e, got;
    if (rst) begin
      m_ready = 0; m_cnt = 0; m_out = '0;
      for (int s = 0; s < 8; s++) for (int w = 0; w < 2; w++) m_mem[s][w] = '0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == 8) m_ready = 1;
    end else begin
      if (rd_en) begin
        for (int w = 0; w < 2; w++) begin
          e[w*256 +: 256] = m_mem[rindex][w];
          if (write_en != 0 && windex == rindex && int'(wway) == w)
            e[w*256 +: 256] = merge(m_mem[rindex][w], datain, write_en);
        end
        sb.push_back(e);
        exp_v = 1;
        m_out = e;
      end
      if (write_en != 0)
        m_mem[windex][wway] = merge(m_mem[windex][wway], datain, write_en);
    end
    tick();
    chk({nm, " ready"}, 512'(ready), 512'(m_ready));
    chk({nm, " rvalid"}, 512'(rvalid), 512'(exp_v));
    if (exp_v) begin
      got = sb.pop_front();
      chk({nm, " dataout"}, dataout, got);
    end else begin
      chk({nm, " dataout hold"}, dataout, m_out);
    end
  endtask

  task automatic idle();
    rst = 0; rd_en = 0; write_en = '0;
  endtask

  typedef struct {
    logic         rd;
    logic [2:0]   ri;
    logic [31:0]  wm;
    logic [2:0]   wi;
    logic [0:0]   ww;
    logic [255:0] din;
    logic         exp_rv;
  } vec_t;

  vec_t tv [10];
  logic [255:0] din_a;

  initial begin
    for (int i = 0; i < 32; i++) din_a[i*8 +: 8] = 8'hA0 + 8'(i);
    //            rd  ri    wm             wi    ww    din             exp_rv
    tv[0] = '{1'b0, 3'd0, 32'hFFFF_FFFF, 3'd5, 1'd0, {32{8'h11}}, 1'b0}; // preload 5/0
    tv[1] = '{1'b1, 3'd5, 32'hFFFF_0000, 3'd5, 1'd0, {32{8'h22}}, 1'b1}; // collision
    tv[2] = '{1'b0, 3'd0, 32'h0000_000F, 3'd3, 1'd1, din_a,       1'b0}; // masked write
    tv[3] = '{1'b1, 3'd3, 32'h0,         3'd0, 1'd0, '0,          1'b1};
    tv[4] = '{1'b0, 3'd0, 32'hFFFF_FFFF, 3'd6, 1'd0, {32{8'h33}}, 1'b0}; // preload 6/0
    tv[5] = '{1'b1, 3'd6, 32'hFFFF_FFFF, 3'd2, 1'd1, {32{8'h44}}, 1'b1}; // independence
    tv[6] = '{1'b1, 3'd2, 32'h0,         3'd0, 1'd0, '0,          1'b1}; // back-to-back
    tv[7] = '{1'b0, 3'd0, 32'h0,         3'd0, 1'd0, '0,          1'b0}; // hold
    tv[8] = '{1'b1, 3'd7, 32'h8000_0001, 3'd5, 1'd1, {32{8'h55}}, 1'b1};
    tv[9] = '{1'b1, 3'd5, 32'h0,         3'd0, 1'd0, '0,          1'b1};

    // T1: reset, sweep; accesses during INIT ignored (set 0 already swept)
    rst = 1; step("rst");
    rst = 0;
    for (int c = 0; c < 8; c++) begin
      rd_en = (c >= 5); rindex = 3'd0;
      write_en = (c >= 5) ? 32'hFFFF_FFFF : '0; windex = 3'd0; wway = 1'd0;
      datain = {32{8'hEE}};
      step($sformatf("init%0d", c));
    end
    idle();
    for (int s = 0; s < 8; s++) begin
      rd_en = 1; rindex = 3'(s);
      step($sformatf("zero_rd%0d", s));
    end

    // T2..T4 table
    for (int k = 0; k < 10; k++) begin
      rd_en = tv[k].rd; rindex = tv[k].ri; write_en = tv[k].wm;
      windex = tv[k].wi; wway = tv[k].ww; datain = tv[k].din;
      step($sformatf("vec%0d", k));
      chk($sformatf("vec%0d rv_tbl", k), 512'(rvalid), 512'(tv[k].exp_rv));
    end
    // Spot checks with literal expectations
    idle(); rd_en = 1; rindex = 3'd5; step("t3_reread");
    chk("t3 way0", 512'(dataout[255:0]), 512'({{16{8'h22}}, {16{8'h11}}}));
    rindex = 3'd3; step("t2_reread");
    chk("t2 way1", 512'(dataout[511:256]), 512'({224'h0, 32'hA3A2A1A0}));
    chk("t2 way0", 512'(dataout[255:0]), 512'h0);

    // A few random accesses
    for (int r = 0; r < 20; r++) begin
      rd_en = 1'($urandom); rindex = 3'($urandom); windex = 3'($urandom);
      wway = 1'($urandom); write_en = ($urandom_range(0, 2) == 0) ? '0 : $urandom;
      for (int i = 0; i < 8; i++) datain[i*32 +: 32] = $urandom;
      step($sformatf("rnd%0d", r));
    end

    // Reset during READY with read and write in flight
    rst = 1; rd_en = 1; rindex = 3'd1; write_en = '1; windex = 3'd1; datain = '1;
    step("rst_ready");
    // T5: reset again at init_cnt=4 with a write on the reset edge
    idle();
    for (int c = 0; c < 4; c++) step($sformatf("t5pre%0d", c));
    rst = 1; write_en = '1; windex = 3'd7; wway = 1'd1; datain = {32{8'h77}};
    step("t5_rst");
    idle();
    for (int c = 0; c < 8; c++) step($sformatf("t5init%0d", c));
    for (int s = 0; s < 8; s++) begin
      rd_en = 1; rindex = 3'(s);
      step($sformatf("t5_rd%0d", s));
    end
    chk("t5 set7", dataout, 512'h0);
    idle(); step("t5_idle");

    // T6: single-way, 2-set instance
    chk("t6 rst ready", 512'(ready1), 512'h0);
    rst1 = 0; tick();
    chk("t6 ready e1", 512'(ready1), 512'h0);
    tick();
    chk("t6 ready e2", 512'(ready1), 512'h1);
    wm1 = '1; wi1 = 1'd0; wway1 = 1'd1; din1 = {32{8'hAA}}; tick();
    wm1 = '0; rd1 = 1; ri1 = 1'd0; tick();
    chk("t6 rvalid", 512'(rvalid1), 512'h1);
    chk("t6 drop", 512'(dout1), 512'h0);
    rd1 = 0; wm1 = '1; wi1 = 1'd1; wway1 = 1'd0; din1 = {32{8'h55}}; tick();
    chk("t6 rvalid idle", 512'(rvalid1), 512'h0);
    wm1 = '0; rd1 = 1; ri1 = 1'd1; tick();
    chk("t6 write", 512'(dout1), 512'({32{8'h55}}));
    rd1 = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
